// File: rtl/shift_pkg.sv
// Shared types for the rolled shifter: shift modes and controller states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package shift_pkg;

  // Encoding matches the 2-bit i_mode port: 0 LSL, 1 LSR, 2 ASR, 3 ROL.
  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROL = 2'd3
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One STEP-bit shift of a WIDTH-bit value in the selected mode.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   value   - operand to shift
//   mode    - LSL / LSR / ASR / ROL
//   shifted - value after one step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] value,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] shifted
);

  logic signed [WIDTH-1:0] value_s;
  assign value_s = value;

  always_comb begin
    shifted = value;
    case (mode)
      SH_LSL: shifted = value << STEP;
      SH_LSR: shifted = value >> STEP;
      SH_ASR: shifted = value_s >>> STEP;
      // Top STEP bits come around to the bottom.
      SH_ROL: shifted = {value[WIDTH-STEP-1:0], value[WIDTH-1:WIDTH-STEP]};
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/rolled_shifter.sv
// Multi-cycle shift engine: loads an operand, then shifts it STEP bits per clock for N steps.
// Latency: o_done is high in the cycle after edge k+N (N = clamped step count, start accepted at edge k).
// Backpressure: i_start is ignored while busy; it is accepted in IDLE and in the DONE cycle.
//
// Ports:
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_a, i_mode, i_steps, i_start - operand, mode, step count, start strobe (sampled together)
//   o_shift - working/result register
//   o_busy  - high while shifting
//   o_done  - one-cycle pulse with the final result on o_shift
module rolled_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int MAX_STEPS = 8,
  parameter int CNT_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_steps,
  output logic [WIDTH-1:0] o_shift,
  output logic             o_busy,
  output logic             o_done
);

  state_t           state;
  shift_mode_t      mode_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] steps_clamped;
  logic [WIDTH-1:0] step_out;

  // Requests above MAX_STEPS are clamped; the saturation/wrap behaviour of
  // long shifts then falls out of repeated single steps.
  assign steps_clamped = (i_steps > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : i_steps;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (o_shift),
    .mode    (mode_q),
    .shifted (step_out)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_shift <= '0;
      mode_q  <= SH_LSL;
      count   <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          o_shift <= step_out;
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end
          if (count <= CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          // DONE accepts a start so back-to-back operations lose no cycle.
          if (i_start) begin
            o_shift <= i_a;
            mode_q  <= shift_mode_t'(i_mode);
            count   <= steps_clamped;
            state   <= (steps_clamped != '0) ? ST_SHIFT : ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state == ST_SHIFT);
  assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_rolled_shifter.sv
// Directed self-checking bench for rolled_shifter (STEP=1 main instance, STEP=2 rotate instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_rolled_shifter;

  localparam logic [1:0] M_LSL = 2'd0;
  localparam logic [1:0] M_LSR = 2'd1;
  localparam logic [1:0] M_ASR = 2'd2;
  localparam logic [1:0] M_ROL = 2'd3;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_a;
  logic       i_start;
  logic       i_start2;
  logic [1:0] i_mode;
  logic [3:0] i_steps;
  logic [7:0] o_shift;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_shift2;
  logic       o_busy2;
  logic       o_done2;

  int errors = 0;
  int checks = 0;

  rolled_shifter #(.WIDTH(8), .STEP(1), .MAX_STEPS(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_a     (i_a),
    .i_start (i_start),
    .i_mode  (i_mode),
    .i_steps (i_steps),
    .o_shift (o_shift),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  rolled_shifter #(.WIDTH(8), .STEP(2), .MAX_STEPS(8)) dut2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_a     (i_a),
    .i_start (i_start2),
    .i_mode  (i_mode),
    .i_steps (i_steps),
    .o_shift (o_shift2),
    .o_busy  (o_busy2),
    .o_done  (o_done2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Strobe one start on the main instance and wait (bounded) for o_done.
  // lat = number of edges after the accepting edge until o_done is seen (-1 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [1:0] mode, input logic [3:0] steps,
                        output logic [7:0] res, output int lat, output int busy_n);
    @(negedge i_clk);
    i_a = a; i_mode = mode; i_steps = steps; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    lat = -1; busy_n = 0; res = 8'hxx;
    for (int j = 0; j < 30; j++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat = j; res = o_shift;
        break;
      end
      if (o_busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b1; i_start2 = 1'b1;
    i_a = 8'h77; i_mode = M_LSL; i_steps = 4'd0;
    repeat (2) @(posedge i_clk);
    #1 i_start = 1'b0; i_start2 = 1'b0; i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_shift, o_busy, o_done} !== 10'h000) begin
      errors++;
      $display("FAIL reset_state: shift=%h busy=%b done=%b, required 00/0/0", o_shift, o_busy, o_done);
    end
    checks++;
    if ({o_shift2, o_busy2, o_done2} !== 10'h000) begin
      errors++;
      $display("FAIL reset_state2: shift=%h busy=%b done=%b, required 00/0/0", o_shift2, o_busy2, o_done2);
    end
  endtask

  task automatic test_lsl;
    logic [7:0] r; int lat; int bn;
    run_op(8'hA5, M_LSL, 4'd3, r, lat, bn);
    checks++;
    if (r !== 8'h28) begin errors++; $display("FAIL lsl_result: got %h, required 28", r); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lsl_latency: got %0d, required 3", lat); end
    checks++;
    if (bn !== 3) begin errors++; $display("FAIL lsl_busy_cycles: got %0d, required 3", bn); end
    @(negedge i_clk);
    checks++;
    if ({o_done, o_shift} !== {1'b0, 8'h28}) begin
      errors++; $display("FAIL lsl_idle_hold: done=%b shift=%h, required 0/28", o_done, o_shift);
    end
  endtask

  task automatic test_right_shifts;
    logic [7:0] r; int lat; int bn;
    run_op(8'h90, M_ASR, 4'd2, r, lat, bn);
    checks++;
    if (r !== 8'hE4) begin errors++; $display("FAIL asr2: got %h, required e4", r); end
    run_op(8'h90, M_LSR, 4'd2, r, lat, bn);
    checks++;
    if (r !== 8'h24) begin errors++; $display("FAIL lsr2: got %h, required 24", r); end
    run_op(8'h90, M_ASR, 4'd10, r, lat, bn);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL asr_clamp: got %h, required ff", r); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL asr_clamp_latency: got %0d, required 8", lat); end
    run_op(8'h90, M_LSL, 4'd8, r, lat, bn);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL lsl_saturate: got %h, required 00", r); end
  endtask

  task automatic test_rol;
    logic [7:0] r; int lat; int bn;
    run_op(8'h81, M_ROL, 4'd1, r, lat, bn);
    checks++;
    if (r !== 8'h03) begin errors++; $display("FAIL rol1: got %h, required 03", r); end
    run_op(8'h81, M_ROL, 4'd8, r, lat, bn);
    checks++;
    if (r !== 8'h81) begin errors++; $display("FAIL rol8: got %h, required 81", r); end
    // STEP=2 instance: 3 steps rotate left by 6.
    @(negedge i_clk);
    i_a = 8'h81; i_mode = M_ROL; i_steps = 4'd3; i_start2 = 1'b1;
    @(posedge i_clk);
    #1 i_start2 = 1'b0;
    lat = -1; r = 8'hxx;
    for (int j = 0; j < 30; j++) begin
      @(negedge i_clk);
      if (o_done2) begin lat = j; r = o_shift2; break; end
    end
    checks++;
    if (r !== 8'h60) begin errors++; $display("FAIL rol_step2: got %h, required 60", r); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rol_step2_latency: got %0d, required 3", lat); end
  endtask

  task automatic test_zero_steps;
    logic [7:0] r; int lat; int bn;
    run_op(8'h5A, M_LSR, 4'd0, r, lat, bn);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL zero_latency: got %0d, required 0", lat); end
    checks++;
    if (r !== 8'h5A) begin errors++; $display("FAIL zero_result: got %h, required 5a", r); end
    checks++;
    if (bn !== 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles, required 0", bn); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [7:0] r;
    @(negedge i_clk);
    i_a = 8'h01; i_mode = M_LSL; i_steps = 4'd4; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    // Re-strobe while busy; must be ignored.
    i_a = 8'hFF; i_mode = M_ASR; i_steps = 4'd1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    lat = -1; r = 8'hxx;
    for (int j = 1; j < 30; j++) begin
      @(negedge i_clk);
      if (o_done) begin lat = j; r = o_shift; break; end
    end
    checks++;
    if (r !== 8'h10) begin errors++; $display("FAIL busy_ignore_result: got %h, required 10", r); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL busy_ignore_latency: got %0d, required 4", lat); end
    // Start in the DONE cycle.
    i_a = 8'h5A; i_mode = M_LSL; i_steps = 4'd1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_done, o_busy, o_shift} !== {1'b0, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL b2b_load: done=%b busy=%b shift=%h, required 0/1/5a", o_done, o_busy, o_shift);
    end
    @(negedge i_clk);
    checks++;
    if ({o_done, o_shift} !== {1'b1, 8'hB4}) begin
      errors++; $display("FAIL b2b_result: done=%b shift=%h, required 1/b4", o_done, o_shift);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    @(negedge i_clk);
    i_a = 8'h01; i_mode = M_LSL; i_steps = 4'd5; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_shift, o_busy, o_done} !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid_op: shift=%h busy=%b done=%b, required 00/0/0", o_shift, o_busy, o_done);
    end
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles, required 0", seen); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_start2 = 1'b0;
    i_a = '0; i_mode = M_LSL; i_steps = '0;
    test_reset();
    test_lsl();
    test_right_shifts();
    test_rol();
    test_zero_steps();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rolled_shifter.md
Name: rolled_shifter

Overview:
- Parametrised, multi-cycle shift engine and successor to the single-step load/left-shift register.
- Loads an operand on a start strobe, then applies STEP bits of shift per clock for a programmed number of steps.
- Supported modes: logical left, logical right, arithmetic right, rotate left.
- Reports busy/done. It is the rolled (one shifter stage reused over time) form of a barrel shifter, used by shift-and-add datapaths in the same design.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- STEP, 1, bits shifted per active cycle (1 <= STEP < WIDTH).
- MAX_STEPS, 8, maximum step count accepted; larger requests are clamped.
- CNT_W, $clog2(MAX_STEPS+1), derived width of the step count; not to be overridden.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_a  input  WIDTH  operand, sampled with i_start.
- i_start  input  1  start strobe; sampled only when accepted (see Behaviour).
- i_mode  input  2  shift mode, sampled with i_start: 0 LSL, 1 LSR, 2 ASR, 3 ROL.
- i_steps  input  CNT_W  number of STEP-bit shifts, sampled with i_start.
- o_shift  output  WIDTH  working/result register.
- o_busy  output  1  high while shifting.
- o_done  output  1  one-cycle pulse; o_shift holds the final result.

Behaviour:
- Reset (i_rst_n=0 at an edge)
  - state=IDLE, o_shift=0, o_busy=0, o_done=0, internal count=0, latched mode=LSL.
  - Reset dominates i_start.
  - Reset mid-operation abandons the operation; no o_done pulse follows.
- States: IDLE, SHIFT, DONE. o_busy = (state==SHIFT). o_done = (state==DONE).
- Start acceptance: i_start is accepted in IDLE or DONE. It is ignored in SHIFT, where the latched operand, mode and count stay unchanged.
- On an accepted start at edge k:
  - o_shift<=i_a; mode latched.
  - count<=min(i_steps, MAX_STEPS).
  - Next state is SHIFT if the clamped count is nonzero, otherwise DONE.
- SHIFT, each edge:
  - o_shift<=step(o_shift, mode); count<=count-1.
  - When count==1 at the edge, next state is DONE.
- Latency: N = clamped count. o_done is high in the cycle after edge k+N, so the result is visible N+1 cycles after the start cycle. With N=0, o_done is high the cycle after the start and o_shift=i_a.
- DONE: lasts exactly one cycle, then IDLE unless a new start is accepted in that cycle (back-to-back). A back-to-back start loads on that same edge, and o_done drops.
- o_shift holds its value in IDLE until the next accepted start.
- Step function (one STEP):
  - LSL: shift left, fill zeros.
  - LSR: shift right, fill zeros.
  - ASR: shift right, fill with the MSB.
  - ROL: rotate left by STEP.
- Total shift is N*STEP and may meet or exceed WIDTH:
  - LSL/LSR saturate to 0.
  - ASR saturates to all sign bits.
  - ROL wraps modulo WIDTH.
- The count decrement never underflows; count is 0 outside SHIFT after completion.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_mode_t {SH_LSL, SH_LSR, SH_ASR, SH_ROL}.
  - typedef enum state_t {ST_IDLE, ST_SHIFT, ST_DONE}.
- Sub-module shift_step: purely combinational one-step shifter, parameters WIDTH and STEP; inputs value and mode; output shifted value. Instantiated once in rolled_shifter, which holds the FSM, counter and register.

Test Plan (WIDTH=8, STEP=1, MAX_STEPS=8 unless stated):
1. i_a=8'hA5, LSL, i_steps=3, single start: o_busy high 3 cycles; o_done pulses 4 cycles after the start cycle with o_shift=8'h28.
2. i_a=8'h90, i_steps=2:
   - ASR gives o_shift=8'hE4 at o_done.
   - LSR gives 8'h24.
   - i_steps=10 with ASR clamps to 8 and gives 8'hFF.
3. ROL, i_a=8'h81:
   - i_steps=1 gives 8'h03.
   - i_steps=8 gives 8'h81.
   - With STEP=2, i_a=8'h81, i_steps=3: o_shift=8'h60.
4. i_steps=0, i_a=8'h5A: o_busy never high; o_done the cycle after start with o_shift=8'h5A.
5. Start ignored while busy: start 8'h01 LSL 4, re-strobe with 8'hFF at step 2. Result is 8'h10 and is unaffected. A start asserted in the o_done cycle loads the new operand on that edge, and o_done does not repeat.
6. i_rst_n=0 for one cycle during step 2 of a 5-step LSL: next cycle o_shift=0, o_busy=0, o_done=0; no later o_done pulse without a new start.
